pipe_stage_skid_reg: RTL and testbench



---
 rtl/pipe_stage_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline stage with a 2-entry skid buffer,
// carrying payload plus hazard metadata (rn, T_new) with flush and T_new ageing.
module pipe_stage_skid_reg #(
    parameter int PAYLOAD_W      = 128,
    parameter int RN_W           = 5,
    parameter int TN_W           = 5,
    parameter bit AGE_WHILE_HELD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [RN_W-1:0]      in_rn,
    input  logic [TN_W-1:0]      in_tnew,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [RN_W-1:0]      out_rn,
    output logic [TN_W-1:0]      out_tnew,
    output logic                 fwd_ok
);
    logic                 r_m_valid   = 1'b0;
    logic [PAYLOAD_W-1:0] r_m_payload = '0;
    logic [RN_W-1:0]      r_m_rn      = '0;
    logic [TN_W-1:0]      r_m_tnew    = '0;
    logic                 r_s_valid   = 1'b0;
    logic [PAYLOAD_W-1:0] r_s_payload = '0;
    logic [RN_W-1:0]      r_s_rn      = '0;
    logic [TN_W-1:0]      r_s_tnew    = '0;

    function automatic logic [TN_W-1:0] sd(input logic [TN_W-1:0] x);
        return (x == '0) ? '0 : x - TN_W'(1);
    endfunction

    logic            w_in_fire;
    logic            w_out_fire;
    logic [TN_W-1:0] w_in_tnew;
    logic [TN_W-1:0] w_m_aged;
    logic [TN_W-1:0] w_s_aged;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_m_valid && out_ready;
    assign w_in_tnew  = sd(in_tnew);
    assign w_m_aged   = AGE_WHILE_HELD ? sd(r_m_tnew) : r_m_tnew;
    assign w_s_aged   = AGE_WHILE_HELD ? sd(r_s_tnew) : r_s_tnew;

    // in_ready depends only on stored state, so back-pressure never ripples combinationally
    assign in_ready    = !r_s_valid;
    assign out_valid   = r_m_valid;
    assign out_payload = r_m_payload;
    assign out_rn      = r_m_valid ? r_m_rn : '0;
    assign out_tnew    = r_m_valid ? r_m_tnew : '0;
    assign fwd_ok      = r_m_valid && (r_m_tnew == '0) && (r_m_rn != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid   <= 1'b0;
            r_m_payload <= '0;
            r_m_rn      <= '0;
            r_m_tnew    <= '0;
            r_s_valid   <= 1'b0;
            r_s_payload <= '0;
            r_s_rn      <= '0;
            r_s_tnew    <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_m_rn    <= '0;
            r_m_tnew  <= '0;
            r_s_valid <= 1'b0;
            r_s_rn    <= '0;
            r_s_tnew  <= '0;
        end else if (!r_m_valid || w_out_fire) begin
            // main is free this cycle: refill from skid first to keep arrival order
            if (r_s_valid) begin
                r_m_payload <= r_s_payload;
                r_m_rn      <= r_s_rn;
                r_m_tnew    <= w_s_aged;
                r_s_valid   <= 1'b0;
            end else begin
                r_m_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_m_payload <= in_payload;
                    r_m_rn      <= in_rn;
                    r_m_tnew    <= w_in_tnew;
                end
            end
        end else begin
            r_m_tnew <= w_m_aged;
            if (w_in_fire) begin
                r_s_valid   <= 1'b1;
                r_s_payload <= in_payload;
                r_s_rn      <= in_rn;
                r_s_tnew    <= w_in_tnew;
            end else begin
                r_s_tnew <= w_s_aged;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: drives two instances (ageing on/off) with directed and
// random traffic, checking every cycle against a queue-style reference model.
module tb_pipe_stage_skid_reg;
    typedef struct packed {
        logic [127:0] p;
        logic [4:0]   rn;
        logic [4:0]   tn;
    } ent_t;
    typedef struct packed {
        logic [1:0]     c;
        ent_t [1:0]     e;
    } mod_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_payload = '0;
    logic [4:0]   in_rn = '0;
    logic [4:0]   in_tnew = '0;
    logic         out_ready = 1'b0;

    logic         o1_in_ready, o1_valid, o1_fwd, o0_in_ready, o0_valid, o0_fwd;
    logic [127:0] o1_payload, o0_payload;
    logic [4:0]   o1_rn, o1_tnew, o0_rn, o0_tnew;

    int tests = 0;
    int fails = 0;
    mod_t md1 = '0;
    mod_t md0 = '0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.AGE_WHILE_HELD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_payload(in_payload), .in_rn(in_rn), .in_tnew(in_tnew), .out_valid(o1_valid),
        .out_ready(out_ready), .out_payload(o1_payload), .out_rn(o1_rn), .out_tnew(o1_tnew),
        .fwd_ok(o1_fwd));

    pipe_stage_skid_reg #(.AGE_WHILE_HELD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_payload(in_payload), .in_rn(in_rn), .in_tnew(in_tnew), .out_valid(o0_valid),
        .out_ready(out_ready), .out_payload(o0_payload), .out_rn(o0_rn), .out_tnew(o0_tnew),
        .fwd_ok(o0_fwd));

    function automatic logic [4:0] sd(input logic [4:0] x);
        return (x > 0) ? x - 5'd1 : 5'd0;
    endfunction

    // Reference: an ordered queue of at most two entries; everything held ages together.
    function automatic mod_t mstep(input mod_t cur, input bit age);
        mod_t nx = cur;
        int   n = int'(cur.c);
        bit   inf = in_valid && (n < 2);
        bit   outf = (n > 0) && out_ready;
        if (reset || flush) begin
            nx.c = 2'd0;
            return nx;
        end
        if (age)
            for (int j = 0; j < 2; j++)
                if (j < n) nx.e[j].tn = sd(nx.e[j].tn);
        if (outf) begin
            nx.e[0] = nx.e[1];
            n--;
        end
        if (inf) begin
            nx.e[n] = '{p: in_payload, rn: in_rn, tn: sd(in_tnew)};
            n++;
        end
        nx.c = 2'(n);
        return nx;
    endfunction

    always @(posedge clk) begin
        md1 <= mstep(md1, 1'b1);
        md0 <= mstep(md0, 1'b0);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mod_t md, input logic ir, input logic ov,
                       input logic [127:0] op, input logic [4:0] orn, input logic [4:0] otn,
                       input logic fo);
        ent_t h = md.e[0];
        bit   v = (md.c != 0);
        chk({tag, "_in_ready"}, ir, md.c < 2);
        chk({tag, "_out_valid"}, ov, v);
        chk({tag, "_out_rn"}, orn, v ? h.rn : 5'd0);
        chk({tag, "_out_tnew"}, otn, v ? h.tn : 5'd0);
        chk({tag, "_fwd_ok"}, fo, v && h.tn == 0 && h.rn != 0);
        if (v) chk({tag, "_out_payload"}, op, h.p);
    endtask

    always @(negedge clk) begin
        cmp("age1", md1, o1_in_ready, o1_valid, o1_payload, o1_rn, o1_tnew, o1_fwd);
        cmp("age0", md0, o0_in_ready, o0_valid, o0_payload, o0_rn, o0_tnew, o0_fwd);
    end

    task automatic push(input logic [127:0] p, input logic [4:0] rn, input logic [4:0] tn);
        in_valid = 1'b1;
        in_payload = p;
        in_rn = rn;
        in_tnew = tn;
    endtask

    initial begin
        int tns[4] = '{2, 1, 0, 3};
        int exs[4] = '{1, 0, 0, 2};
        int aex[5] = '{3, 2, 1, 0, 0};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", o1_valid, 0);
        chk("rst_out_payload", o1_payload, 0);
        chk("rst_out_rn", o1_rn, 0);
        chk("rst_out_tnew", o1_tnew, 0);
        chk("rst_in_ready", o1_in_ready, 1);
        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(128'(i + 16), 5'(i + 1), 5'(tns[i]));
            @(negedge clk);
            chk("stream_valid", o1_valid, 1);
            chk("stream_tnew", o1_tnew, 128'(exs[i]));
            chk("stream_payload", o1_payload, 128'(i + 16));
            chk("stream_in_ready", o1_in_ready, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drained", o1_valid, 0);
        // back-pressure
        out_ready = 1'b0;
        push(128'hA, 5'd2, 5'd9);
        @(negedge clk);
        chk("bp_ready_one", o1_in_ready, 1);
        push(128'hB, 5'd2, 5'd9);
        @(negedge clk);
        chk("bp_ready_full", o1_in_ready, 0);
        push(128'hC, 5'd2, 5'd9);
        @(negedge clk);
        chk("bp_third_refused", o1_in_ready, 0);
        chk("bp_head_a", o1_payload, 128'hA);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", o1_payload, 128'hB);
        chk("bp_ready_back", o1_in_ready, 1);
        @(negedge clk);
        chk("bp_no_c", o1_valid, 0);
        // ageing while held
        out_ready = 1'b0;
        push(128'h7, 5'd7, 5'd4);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("age1_tnew", o1_tnew, 128'(aex[i]));
            chk("age1_fwd", o1_fwd, aex[i] == 0);
            chk("age0_tnew", o0_tnew, 3);
            @(negedge clk);
        end
        // flush while full, with a pending input
        push(128'h5, 5'd5, 5'd0);
        @(negedge clk);
        chk("fl_full", o1_in_ready, 0);
        flush = 1'b1;
        push(128'hF, 5'd6, 5'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", o1_valid, 0);
        chk("fl_rn", o1_rn, 0);
        chk("fl_fwd", o1_fwd, 0);
        chk("fl_in_ready", o1_in_ready, 1);
        flush = 1'b1;
        push(128'hE, 5'd6, 5'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_discard", o1_valid, 0);
        // reset mid-stream while full
        push(128'h1, 5'd1, 5'd2);
        @(negedge clk);
        push(128'h2, 5'd2, 5'd2);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        push(128'h3, 5'd3, 5'd3);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", o1_valid, 0);
        chk("mrst_payload", o1_payload, 0);
        chk("mrst_rn", o1_rn, 0);
        chk("mrst_tnew", o1_tnew, 0);
        chk("mrst_fwd", o1_fwd, 0);
        chk("mrst_in_ready", o1_in_ready, 1);
        out_ready = 1'b0;
        push(128'hC, 5'd3, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("c_rn", o1_rn, 3);
        chk("c_tnew", o1_tnew, 0);
        chk("c_fwd", o1_fwd, 1);
        // rn=0 never forwards
        out_ready = 1'b1;
        push(128'hD, 5'd0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rn0_valid", o1_valid, 1);
        chk("rn0_fwd", o1_fwd, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_payload = {$urandom, $urandom, $urandom, $urandom};
            in_rn = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            in_tnew = 5'($urandom_range(0, 5));
            flush = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
